muldiv_controller: RTL

- Iterative multiply/divide sequencer for the EX stage of the pipelined MIPS core.
- Owns the HI/LO architectural registers and runs MULT, MULTU, DIV and DIVU over multiple cycles with a shift-add / restoring-divide datapath.
- Asserts a stall request to the hazard unit whenever the pipeline issues a new mul/div or touches HI/LO while an operation is in flight.

---
 rtl/muldiv_controller_if.sv | 29 ++
 rtl/muldiv_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_controller_if.sv
// Handshake/data bundle between the EX stage and the multiply/divide sequencer.
// Also carries the sequencer's FSM state out for observation.
interface muldiv_controller_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hilo_read;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
  logic [1:0]       state;

  modport master (
    output start, op, rs_data, rt_data, hilo_read, mthi, mtlo, wdata, flush,
    input  hi, lo, busy, done, stall, state
  );

  modport slave (
    input  start, op, rs_data, rt_data, hilo_read, mthi, mtlo, wdata, flush,
    output hi, lo, busy, done, stall, state
  );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO (shift-add / restoring divide).
// Optional MULDIV_EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
module muldiv_controller #(
  parameter int WIDTH = 32
) (
  input logic           CLK,
  input logic           nRST,
  muldiv_controller_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;   // multiply: product; divide: {remainder, quotient}
  logic [2*WIDTH-1:0] mcand_q, mcand_d; // multiply: shifted multiplicand; divide: divisor in low half
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  assign signed_op = ~bus.op[0];
  assign rs_neg    = signed_op & bus.rs_data[WIDTH-1];
  assign rt_neg    = signed_op & bus.rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;

  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  // Restoring step: shift {rem,quo} left one and try to subtract the divisor.
  assign rem_sh   = prod_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = (rem_sh >= {1'b0, mcand_q[WIDTH-1:0]});
  assign rem_diff = rem_sh[WIDTH-1:0] - mcand_q[WIDTH-1:0];

  assign prod_fixed = neg_q ? -prod_q : prod_q;
  assign quo_fixed  = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fixed  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.start) begin
          is_div_d = bus.op[1];
          cnt_d    = '0;
          neg_d    = rs_neg ^ rt_neg;
          state_d  = S_ITER;
          if (bus.op[1]) begin
            neg_rem_d = rs_neg;
            prod_d    = {{WIDTH{1'b0}}, rs_mag};
            mcand_d   = {{WIDTH{1'b0}}, rt_mag};
            if (bus.rt_data == '0) begin
              // Divide by zero: FIX publishes hi = raw dividend, lo = all ones.
              prod_d    = {bus.rs_data, {WIDTH{1'b1}}};
              neg_d     = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = S_FIX;
            end
          end else begin
            neg_rem_d = 1'b0;
            prod_d    = '0;
            mcand_d   = {{WIDTH{1'b0}}, rs_mag};
            mplier_d  = rt_mag;
`ifdef MULDIV_EARLY_TERM_EN
            if (rt_mag == '0) state_d = S_FIX;
`endif
          end
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      S_ITER: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            prod_d = rem_ge ? {rem_diff, prod_q[WIDTH-2:0], 1'b1}
                            : {prod_q[2*WIDTH-2:0], 1'b0};
          end else begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
`ifdef MULDIV_EARLY_TERM_EN
          else if (!is_div_q && (mplier_q[WIDTH-1:1] == '0)) begin
            state_d = S_FIX;
          end
`endif
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          if (is_div_q) begin
            lo_d = quo_fixed;
            hi_d = rem_fixed;
          end else begin
            {hi_d, lo_d} = prod_fixed;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_q == S_FIX) && !bus.flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Pipeline holds any mul/div or HI/LO access while an operation is in flight.
  assign bus.stall = busy_q & (bus.start | bus.hilo_read | bus.mthi | bus.mtlo);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;
endmodule
